mem_arbiter: RTL and testbench

- Sits between the fetch stage, the MEM stage and the byte-serial memory controller.
- Holds up to SB_DEPTH committed stores in a FIFO store buffer, acknowledging each the cycle after acceptance.
- Grants the single downstream port to one of three sources (IF fetch, MEM load, store-buffer drain) with fixed priority plus an IF anti-starvation counter.
- Handles fetch cancellation on pc jump without disturbing in-flight transfers.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory controller port between the
// instruction fetch path, MEM-stage loads and a FIFO store buffer drain.
// Optional macro LOAD_BYPASS_EN lets loads pass buffered stores to other words.
module mem_arbiter #(
    parameter int SB_DEPTH      = 4,
    parameter int IF_STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        flush_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    input  logic        mem_req_i,
    input  logic        mem_wr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_type_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_done_o,
    output logic [31:0] mem_rdata_o,
    output logic        sb_empty_o,
    output logic        dn_valid_o,
    output logic        dn_wr_o,
    output logic [31:0] dn_addr_o,
    output logic [1:0]  dn_type_o,
    output logic [31:0] dn_wdata_o,
    input  logic        dn_done_i,
    input  logic [31:0] dn_rdata_i
);
    localparam int AW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(IF_STARVE_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_IF, S_LD, S_ST} state_t;

    state_t      r_state, w_state_next;
    logic [AW:0] r_wptr, r_rptr, w_count;
    logic [CW-1:0] r_starve;
    logic        r_drop;
    logic        r_if_valid, r_mem_done, r_dn_valid, r_dn_wr;
    logic [31:0] r_if_inst, r_mem_rdata, r_dn_addr, r_dn_wdata;
    logic [1:0]  r_dn_type;

    // Store buffer storage; pointers carry one extra wrap bit
    logic [31:0] r_sb_addr [SB_DEPTH];
    logic [1:0]  r_sb_type [SB_DEPTH];
    logic [31:0] r_sb_data [SB_DEPTH];

    logic w_full, w_empty, w_push, w_if_req, w_ld_req, w_ld_ok;
    logic w_grant_if, w_grant_ld, w_grant_st;
    logic [1:0] w_type_norm;
    logic [AW-1:0] w_head;

    assign w_count     = r_wptr - r_rptr;
    assign w_full      = (w_count == (AW+1)'(SB_DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_head      = r_rptr[AW-1:0];
    // Back-to-back accept is blocked while the previous done pulse is visible
    assign w_push      = mem_req_i & mem_wr_i & ~w_full & ~r_mem_done;
    assign w_if_req    = if_req_i & ~flush_i;
    assign w_ld_req    = mem_req_i & ~mem_wr_i;
    assign w_type_norm = (mem_type_i == 2'd2) ? 2'd3 : mem_type_i;

`ifdef LOAD_BYPASS_EN
    // Word-granular overlap check of the pending load against live entries
    logic [SB_DEPTH-1:0] w_hit;
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_hit
            logic [AW-1:0] w_off;
            assign w_off      = AW'(gi) - w_head;
            assign w_hit[gi]  = ({1'b0, w_off} < w_count) &&
                                (r_sb_addr[gi][31:2] == mem_addr_i[31:2]);
        end
    endgenerate
    assign w_ld_ok = ~(|w_hit);
`else
    assign w_ld_ok = w_empty;
`endif

    // Fixed-priority arbitration in IDLE; busy states wait for completion
    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_ld   = 1'b0;
        w_grant_st   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_full)                                           w_grant_st = 1'b1;
                else if (r_starve == CW'(IF_STARVE_MAX) && w_if_req)  w_grant_if = 1'b1;
                else if (w_ld_req && w_ld_ok)                         w_grant_ld = 1'b1;
                else if (w_if_req)                                    w_grant_if = 1'b1;
                else if (!w_empty)                                    w_grant_st = 1'b1;
                if (w_grant_st)      w_state_next = S_ST;
                else if (w_grant_if) w_state_next = S_IF;
                else if (w_grant_ld) w_state_next = S_LD;
            end
            default: begin
                if (dn_done_i) w_state_next = S_IDLE;
            end
        endcase
    end

    // Store buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (!rst && rdy && w_push) begin
            r_sb_addr[r_wptr[AW-1:0]] <= mem_addr_i;
            r_sb_type[r_wptr[AW-1:0]] <= w_type_norm;
            r_sb_data[r_wptr[AW-1:0]] <= mem_wdata_i;
        end
    end

    // Control state, downstream request registers and response pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_starve    <= '0;
            r_drop      <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_inst   <= '0;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= '0;
            r_dn_valid  <= 1'b0;
            r_dn_wr     <= 1'b0;
            r_dn_addr   <= '0;
            r_dn_type   <= '0;
            r_dn_wdata  <= '0;
        end else if (rdy) begin
            r_state    <= w_state_next;
            r_if_valid <= 1'b0;
            r_mem_done <= w_push;
            if (w_push) r_wptr <= r_wptr + 1'b1;

            if (w_grant_if) begin
                r_dn_valid <= 1'b1;
                r_dn_wr    <= 1'b0;
                r_dn_addr  <= if_addr_i;
                r_dn_type  <= 2'd3;
                r_dn_wdata <= '0;
            end else if (w_grant_ld) begin
                r_dn_valid <= 1'b1;
                r_dn_wr    <= 1'b0;
                r_dn_addr  <= mem_addr_i;
                r_dn_type  <= w_type_norm;
                r_dn_wdata <= '0;
            end else if (w_grant_st) begin
                r_dn_valid <= 1'b1;
                r_dn_wr    <= 1'b1;
                r_dn_addr  <= r_sb_addr[w_head];
                r_dn_type  <= r_sb_type[w_head];
                r_dn_wdata <= r_sb_data[w_head];
            end

            if (r_state != S_IDLE && dn_done_i) begin
                r_dn_valid <= 1'b0;
                case (r_state)
                    S_IF: begin
                        if (!r_drop && !flush_i) begin
                            r_if_valid <= 1'b1;
                            r_if_inst  <= dn_rdata_i;
                        end
                    end
                    S_LD: begin
                        r_mem_done  <= 1'b1;
                        r_mem_rdata <= dn_rdata_i;
                    end
                    default: r_rptr <= r_rptr + 1'b1;
                endcase
            end

            if (r_state == S_IF) begin
                if (dn_done_i)    r_drop <= 1'b0;
                else if (flush_i) r_drop <= 1'b1;
            end

            if (!w_if_req || w_grant_if)
                r_starve <= '0;
            else if (r_state != S_IF && r_starve != CW'(IF_STARVE_MAX))
                r_starve <= r_starve + 1'b1;
        end
    end

    assign if_valid_o  = r_if_valid;
    assign if_inst_o   = r_if_inst;
    assign mem_done_o  = r_mem_done;
    assign mem_rdata_o = r_mem_rdata;
    assign sb_empty_o  = w_empty;
    assign dn_valid_o  = r_dn_valid;
    assign dn_wr_o     = r_dn_wr;
    assign dn_addr_o   = r_dn_addr;
    assign dn_type_o   = r_dn_type;
    assign dn_wdata_o  = r_dn_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a hand-driven
// memory controller; expected values are written out per step.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req_i, flush_i, if_valid_o;
    logic [31:0] if_addr_i, if_inst_o;
    logic        mem_req_i, mem_wr_i, mem_done_o, sb_empty_o;
    logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic [1:0]  mem_type_i, dn_type_o;
    logic        dn_valid_o, dn_wr_o, dn_done_i;
    logic [31:0] dn_addr_o, dn_wdata_o, dn_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.SB_DEPTH(4), .IF_STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .flush_i(flush_i),
        .if_valid_o(if_valid_o), .if_inst_o(if_inst_o),
        .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
        .mem_type_i(mem_type_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o), .sb_empty_o(sb_empty_o),
        .dn_valid_o(dn_valid_o), .dn_wr_o(dn_wr_o), .dn_addr_o(dn_addr_o),
        .dn_type_o(dn_type_o), .dn_wdata_o(dn_wdata_o),
        .dn_done_i(dn_done_i), .dn_rdata_i(dn_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s 0x%08h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dn(input string tag);
        int n = 0;
        while (!dn_valid_o && n < 40) begin
            tick;
            n++;
        end
        chk({tag, ".dn_valid"}, 32'(dn_valid_o), 32'd1);
    endtask

    // Wait for a downstream request, check it, hold it lat cycles, complete it
    task automatic serve(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [1:0] typ, input int lat,
                         input logic [31:0] rdata, input logic [31:0] wdata);
        wait_dn(tag);
        chk({tag, ".addr"}, dn_addr_o, addr);
        chk({tag, ".wr"}, 32'(dn_wr_o), 32'(wr));
        chk({tag, ".type"}, 32'(dn_type_o), 32'(typ));
        if (wr) chk({tag, ".wdata"}, dn_wdata_o, wdata);
        repeat (lat) tick;
        if (lat > 0) chk({tag, ".hold"}, dn_addr_o, addr);
        dn_done_i  = 1'b1;
        dn_rdata_i = rdata;
        tick;
        dn_done_i  = 1'b0;
        dn_rdata_i = '0;
    endtask

    task automatic store_push(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_type_i = 2'd3;
        mem_addr_i = addr; mem_wdata_i = data;
        tick;
        while (!mem_done_o && n < 20) begin
            tick;
            n++;
        end
        chk({tag, ".done"}, 32'(mem_done_o), 32'd1);
        mem_req_i = 1'b0; mem_wr_i = 1'b0;
    endtask

    task automatic load_req(input logic [31:0] addr);
        mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_type_i = 2'd3; mem_addr_i = addr;
    endtask

    initial begin
        int seen;
        int n;
        rst = 1'b1; rdy = 1'b1;
        if_req_i = 0; if_addr_i = '0; flush_i = 0;
        mem_req_i = 0; mem_wr_i = 0; mem_addr_i = '0; mem_type_i = '0; mem_wdata_i = '0;
        dn_done_i = 0; dn_rdata_i = '0;
        repeat (3) tick;
        chk("rst.dn_valid", 32'(dn_valid_o), 32'd0);
        chk("rst.sb_empty", 32'(sb_empty_o), 32'd1);
        chk("rst.if_valid", 32'(if_valid_o), 32'd0);
        chk("rst.mem_done", 32'(mem_done_o), 32'd0);
        chk("rst.dn_addr", dn_addr_o, 32'd0);
        chk("rst.if_inst", if_inst_o, 32'd0);
        rst = 1'b0;

        // Basic fetch
        if_req_i = 1'b1; if_addr_i = 32'h100;
        serve("if1", 32'h100, 1'b0, 2'd3, 5, 32'h00A00093, 32'h0);
        chk("if1.valid", 32'(if_valid_o), 32'd1);
        chk("if1.inst", if_inst_o, 32'h00A00093);
        if_req_i = 1'b0;
        tick;
        chk("if1.pulse_end", 32'(if_valid_o), 32'd0);
        chk("if1.inst_hold", if_inst_o, 32'h00A00093);

        // Fill the store buffer, fifth store stalls, drain in order
        for (int i = 0; i < 4; i++)
            store_push($sformatf("st%0d", i), 32'h10 + 32'(4*i), 32'hA0 + 32'(i));
        chk("sb.not_empty", 32'(sb_empty_o), 32'd0);
        mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h20; mem_wdata_i = 32'hA4;
        seen = 0;
        repeat (6) begin
            tick;
            if (mem_done_o) seen = 1;
        end
        chk("st4.stall", 32'(seen), 32'd0);
        serve("drain0", 32'h10, 1'b1, 2'd3, 0, 32'h0, 32'hA0);
        n = 0;
        while (!mem_done_o && n < 10) begin
            tick;
            n++;
        end
        chk("st4.done", 32'(mem_done_o), 32'd1);
        mem_req_i = 1'b0; mem_wr_i = 1'b0;
        for (int i = 1; i < 5; i++)
            serve($sformatf("drain%0d", i), 32'h10 + 32'(4*i), 1'b1, 2'd3, 1, 32'h0, 32'hA0 + 32'(i));
        chk("sb.empty_after", 32'(sb_empty_o), 32'd1);

        // Load to a buffered address waits for the store
        store_push("s20", 32'h20, 32'h55550020);
        load_req(32'h20);
        serve("ord.st", 32'h20, 1'b1, 2'd3, 2, 32'h0, 32'h55550020);
        serve("ord.ld", 32'h20, 1'b0, 2'd3, 1, 32'h12345678, 32'h0);
        chk("ord.done", 32'(mem_done_o), 32'd1);
        chk("ord.rdata", mem_rdata_o, 32'h12345678);
        mem_req_i = 1'b0;
`ifdef LOAD_BYPASS_EN
        store_push("byp.s24", 32'h24, 32'h24);
        load_req(32'h40);
        serve("byp.ld40", 32'h40, 1'b0, 2'd3, 1, 32'h40404040, 32'h0);
        mem_req_i = 1'b0;
        serve("byp.st24", 32'h24, 1'b1, 2'd3, 1, 32'h0, 32'h24);
        store_push("byp.s20", 32'h20, 32'h20);
        load_req(32'h22);
        serve("byp.st20", 32'h20, 1'b1, 2'd3, 1, 32'h0, 32'h20);
        serve("byp.ld22", 32'h22, 1'b0, 2'd3, 1, 32'h22222222, 32'h0);
        mem_req_i = 1'b0;
`endif

        // IF starvation: three loads win, then the counter forces IF
        if_req_i = 1'b1; if_addr_i = 32'h400;
        load_req(32'h80);
        serve("stv.ld80", 32'h80, 1'b0, 2'd3, 1, 32'h10000080, 32'h0);
        chk("stv.rdata80", mem_rdata_o, 32'h10000080);
        load_req(32'h84);
        serve("stv.ld84", 32'h84, 1'b0, 2'd3, 1, 32'h10000084, 32'h0);
        load_req(32'h88);
        serve("stv.ld88", 32'h88, 1'b0, 2'd3, 1, 32'h10000088, 32'h0);
        load_req(32'h8C);
        serve("stv.if400", 32'h400, 1'b0, 2'd3, 1, 32'h00000413, 32'h0);
        chk("stv.if_valid", 32'(if_valid_o), 32'd1);
        chk("stv.if_inst", if_inst_o, 32'h00000413);
        if_addr_i = 32'h404;
        serve("stv.ld8c", 32'h8C, 1'b0, 2'd3, 1, 32'h1000008C, 32'h0);
        chk("stv.done8c", 32'(mem_done_o), 32'd1);
        mem_req_i = 1'b0;
        serve("stv.if404", 32'h404, 1'b0, 2'd3, 1, 32'h00000414, 32'h0);
        if_req_i = 1'b0;

        // Flush during an outstanding fetch drops its result
        if_req_i = 1'b1; if_addr_i = 32'h200;
        wait_dn("fl.200");
        chk("fl.addr200", dn_addr_o, 32'h200);
        flush_i = 1'b1; if_addr_i = 32'h300;
        tick;
        flush_i = 1'b0;
        serve("fl.200c", 32'h200, 1'b0, 2'd3, 1, 32'hBAD0BAD0, 32'h0);
        chk("fl.dropped", 32'(if_valid_o), 32'd0);
        chk("fl.inst_hold", if_inst_o, 32'h00000414);
        wait_dn("fl.300");
        chk("fl.addr300", dn_addr_o, 32'h300);
        flush_i = 1'b1; dn_done_i = 1'b1; dn_rdata_i = 32'hBAD1BAD1; if_addr_i = 32'h304;
        tick;
        flush_i = 1'b0; dn_done_i = 1'b0; dn_rdata_i = '0;
        chk("fl.coinc_drop", 32'(if_valid_o), 32'd0);
        serve("fl.304", 32'h304, 1'b0, 2'd3, 2, 32'h00000013, 32'h0);
        chk("fl.valid304", 32'(if_valid_o), 32'd1);
        chk("fl.inst304", if_inst_o, 32'h00000013);
        if_req_i = 1'b0;

        // rdy low freezes an outstanding load and holds a done pulse
        load_req(32'h90);
        wait_dn("rdy.ld");
        rdy = 1'b0; dn_done_i = 1'b1; dn_rdata_i = 32'hDEADDEAD;
        tick;
        dn_done_i = 1'b0; dn_rdata_i = '0;
        tick;
        tick;
        chk("rdy.dn_valid", 32'(dn_valid_o), 32'd1);
        chk("rdy.no_done", 32'(mem_done_o), 32'd0);
        chk("rdy.addr", dn_addr_o, 32'h90);
        rdy = 1'b1;
        serve("rdy.ld90", 32'h90, 1'b0, 2'd3, 0, 32'h00009090, 32'h0);
        chk("rdy.rdata", mem_rdata_o, 32'h00009090);
        mem_req_i = 1'b0;
        rdy = 1'b0;
        tick;
        tick;
        chk("rdy.done_hold", 32'(mem_done_o), 32'd1);
        rdy = 1'b1;
        tick;
        chk("rdy.done_end", 32'(mem_done_o), 32'd0);

        // Reset during a store drain discards everything
        store_push("rs.a0", 32'hA0, 32'h000000A0);
        store_push("rs.a4", 32'hA4, 32'h000000A4);
        wait_dn("rs.st");
        chk("rs.addr", dn_addr_o, 32'hA0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rs.dn_valid", 32'(dn_valid_o), 32'd0);
        chk("rs.sb_empty", 32'(sb_empty_o), 32'd1);
        chk("rs.mem_done", 32'(mem_done_o), 32'd0);
        seen = 0;
        repeat (4) begin
            tick;
            if (dn_valid_o || mem_done_o || if_valid_o) seen = 1;
        end
        chk("rs.quiet", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
